// File: rtl/word_counter_bank_if.sv
// Read port of the word counter bank: level-sensitive request with channel index,
// answered one clock later by a registered count, its qualifier and an index-error pulse.
interface word_counter_bank_if #(
    parameter int IDX_WIDTH   = 2,
    parameter int COUNT_WIDTH = 5
);
    logic                   req;
    logic [IDX_WIDTH-1:0]   idx;
    logic [COUNT_WIDTH-1:0] data;
    logic                   valid;
    logic                   idx_err;

    // Handshake: a read is taken in every cycle where req=1 and the bank's idle input is 1;
    // valid=1 in the following cycle qualifies data (and idx_err). There is no backpressure.
    modport master (output req, idx, input data, valid, idx_err);
    modport slave  (input req, idx, output data, valid, idx_err);
endinterface

// File: rtl/word_counter_bank.sv
// Per-channel saturating word counters for the output FIFOs, with a one-cycle-latency
// read port that only serves while the transaction FSM is idle.
module word_counter_bank #(
    parameter int NUM_CHANNELS  = 4,
    parameter int COUNT_WIDTH   = 5,
    parameter int IDX_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] pop,
    input  logic [NUM_CHANNELS-1:0] empty,
    input  logic                    idle,
    word_counter_bank_if.slave      rd,
    output logic [NUM_CHANNELS-1:0] overflow,
    output logic [1:0]              fsm_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t                 state;
    logic                   serve;
    logic                   hit;
    logic [COUNT_WIDTH-1:0] sel;
    logic [COUNT_WIDTH-1:0] count [NUM_CHANNELS];

    assign serve     = rd.req & idle;
    assign fsm_state = state;

    // hit stays low for indices past the last channel when NUM_CHANNELS is not a power of 2
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rd.idx == IDX_WIDTH'(i)) begin
                sel = count[i];
                hit = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic                   ev;
        logic                   clr;
        logic [COUNT_WIDTH-1:0] cnt_q;
        logic                   ovf_q;

        assign ev       = pop[i] & ~empty[i];
        assign clr      = (CLEAR_ON_READ != 0) && serve && (rd.idx == IDX_WIDTH'(i));
        assign count[i] = cnt_q;
        assign overflow[i] = ovf_q;

        // A clear and a same-cycle event leave the counter at 1 so the event is kept.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (clr) begin
                cnt_q <= {{(COUNT_WIDTH-1){1'b0}}, ev};
                ovf_q <= 1'b0;
            end else if (ev) begin
                if (&cnt_q) ovf_q <= 1'b1;
                else        cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rd.data    <= '0;
            rd.valid   <= 1'b0;
            rd.idx_err <= 1'b0;
        end else begin
            rd.valid   <= serve;
            rd.idx_err <= serve & ~hit;
            if (serve) rd.data <= hit ? sel : '0;
            case (state)
                S_IDLE: begin
                    if (rd.req) state <= idle ? S_SERVE : S_WAIT;
                end
                S_WAIT: begin
                    if (!rd.req)   state <= S_IDLE;
                    else if (idle) state <= S_SERVE;
                end
                S_SERVE: begin
                    if (!rd.req)    state <= S_IDLE;
                    else if (!idle) state <= S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_word_counter_bank.sv
// Bench for word_counter_bank: a 4-channel/5-bit non-destructive bank and a
// 3-channel/3-bit clear-on-read bank driven side by side against a behavioural model.
module tb_word_counter_bank;
    localparam int NA = 4, WA = 5, NB = 3, WB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          idle;
    logic [NA-1:0] pop_a, empty_a, ovf_a;
    logic [NB-1:0] pop_b, empty_b, ovf_b;
    logic [1:0]    st_a, st_b;

    word_counter_bank_if #(.IDX_WIDTH(2), .COUNT_WIDTH(WA)) rd_a ();
    word_counter_bank_if #(.IDX_WIDTH(2), .COUNT_WIDTH(WB)) rd_b ();

    word_counter_bank #(.NUM_CHANNELS(NA), .COUNT_WIDTH(WA), .CLEAR_ON_READ(0)) dut_a (
        .clk(clk), .reset(reset), .pop(pop_a), .empty(empty_a), .idle(idle),
        .rd(rd_a.slave), .overflow(ovf_a), .fsm_state(st_a)
    );
    word_counter_bank #(.NUM_CHANNELS(NB), .COUNT_WIDTH(WB), .CLEAR_ON_READ(1)) dut_b (
        .clk(clk), .reset(reset), .pop(pop_b), .empty(empty_b), .idle(idle),
        .rd(rd_b.slave), .overflow(ovf_b), .fsm_state(st_b)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state, bank 0 = A, bank 1 = B
    int cnt_m [2][16];
    int ovf_m [2][16];
    int data_m [2];
    int valid_m [2];
    int err_m [2];
    int st_m [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) begin
                cnt_m[b][i] = 0;
                ovf_m[b][i] = 0;
            end
            data_m[b] = 0; valid_m[b] = 0; err_m[b] = 0; st_m[b] = 0;
        end
    endtask

    task automatic model_step(input int b, input int nch, input int w, input int cor,
                              input int popv, input int emptyv, input int req,
                              input int idl, input int idx);
        int maxv;
        bit served;
        maxv = (1 << w) - 1;
        served = (req != 0) && (idl != 0);
        valid_m[b] = served;
        err_m[b] = 0;
        if (served) begin
            if (idx >= nch) begin
                data_m[b] = 0;
                err_m[b] = 1;
            end else begin
                data_m[b] = cnt_m[b][idx];
            end
        end
        for (int i = 0; i < nch; i++) begin
            bit ev;
            ev = (((popv >> i) & 1) == 1) && (((emptyv >> i) & 1) == 0);
            if (served && cor != 0 && idx == i) begin
                cnt_m[b][i] = 0;
                ovf_m[b][i] = 0;
            end
            if (ev) begin
                if (cnt_m[b][i] + 1 > maxv) ovf_m[b][i] = 1;
                else cnt_m[b][i] = cnt_m[b][i] + 1;
            end
        end
        st_m[b] = served ? 2 : ((req != 0) ? 1 : 0);
    endtask

    function automatic int ovf_pack(input int b);
        int o = 0;
        for (int i = 0; i < 16; i++) o |= ovf_m[b][i] << i;
        return o;
    endfunction

    task automatic compare();
        check("a_data",  rd_a.data,    data_m[0]);
        check("a_valid", rd_a.valid,   valid_m[0]);
        check("a_err",   rd_a.idx_err, err_m[0]);
        check("a_ovf",   ovf_a,        ovf_pack(0));
        check("a_state", st_a,         st_m[0]);
        check("b_data",  rd_b.data,    data_m[1]);
        check("b_valid", rd_b.valid,   valid_m[1]);
        check("b_err",   rd_b.idx_err, err_m[1]);
        check("b_ovf",   ovf_b,        ovf_pack(1));
        check("b_state", st_b,         st_m[1]);
    endtask

    // driver: inputs are set at posedge+1, the model consumes them, then the edge
    task automatic step();
        model_step(0, NA, WA, 0, pop_a, empty_a, rd_a.req, idle, rd_a.idx);
        model_step(1, NB, WB, 1, pop_b, empty_b, rd_b.req, idle, rd_b.idx);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drive(input int pa, input int pb, input int ra, input int ia,
                         input int rb, input int ib, input int idl);
        pop_a = NA'(pa); empty_a = '0;
        pop_b = NB'(pb); empty_b = '0;
        rd_a.req = ra[0]; rd_a.idx = 2'(ia);
        rd_b.req = rb[0]; rd_b.idx = 2'(ib);
        idle = idl[0];
    endtask

    // asynchronous reset between edges; outputs must clear without a clock
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_a_data",  rd_a.data, 0);
        check("rst_a_valid", rd_a.valid, 0);
        check("rst_a_ovf",   ovf_a, 0);
        check("rst_b_data",  rd_b.data, 0);
        check("rst_b_valid", rd_b.valid, 0);
        check("rst_b_ovf",   ovf_b, 0);
        check("rst_a_state", st_a, 0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 5 pops on channel 0, single read
        for (int k = 0; k < 5; k++) begin drive(1, 1, 0, 0, 0, 0, 1); step(); end
        drive(0, 0, 1, 0, 1, 0, 1); step();
        check("t1_data", rd_a.data, 5);
        check("t1_valid", rd_a.valid, 1);
        drive(0, 0, 0, 0, 0, 0, 1); step();
        check("t1_valid_drop", rd_a.valid, 0);

        // saturation, then reset in the middle of a read stream
        do_reset();
        for (int k = 0; k < 40; k++) begin drive(8, 4, 0, 0, 0, 0, 1); step(); end
        check("t2_ovf", ovf_a, 8);
        drive(8, 4, 1, 3, 1, 2, 1); step();
        check("t2_data", rd_a.data, 31);
        drive(8, 4, 1, 3, 1, 2, 1);
        do_reset();

        // wait for idle, then withdraw a waiting request
        for (int k = 0; k < 6; k++) begin drive(2, 2, 0, 0, 0, 0, 1); step(); end
        for (int k = 0; k < 3; k++) begin drive(0, 0, 1, 1, 1, 1, 0); step(); end
        check("t3_wait_valid", rd_a.valid, 0);
        drive(0, 0, 1, 1, 1, 1, 1); step();
        check("t3_data", rd_a.data, 6);
        check("t3_valid", rd_a.valid, 1);
        drive(0, 0, 1, 1, 1, 1, 0); step();
        for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 1, 0, 1, 1); step(); end
        check("t3_withdrawn", rd_a.valid, 0);

        // streaming reads with idx stepping every cycle
        do_reset();
        for (int k = 0; k < 12; k++) begin
            int pa;
            pa = (k < 2 ? 1 : 0) | (k < 5 ? 2 : 0) | (k < 2 ? 4 : 0) | 8;
            drive(pa, pa & 7, 0, 0, 0, 0, 1); step();
        end
        for (int k = 0; k < 4; k++) begin
            int exp_a [4] = '{2, 5, 2, 12};
            drive(0, 0, 1, k, 0, 0, 1); step();
            check("t4_data", rd_a.data, exp_a[k]);
        end

        // clear-on-read with a same-cycle count event, out-of-range index, pop on empty
        do_reset();
        for (int k = 0; k < 4; k++) begin drive(0, 4, 0, 0, 0, 0, 1); step(); end
        drive(0, 4, 0, 0, 1, 2, 1); step();
        check("t5_data", rd_b.data, 4);
        drive(0, 0, 0, 0, 1, 2, 1); step();
        check("t5_reread", rd_b.data, 1);
        drive(0, 0, 0, 0, 1, 3, 1); step();
        check("t6_err", rd_b.idx_err, 1);
        check("t6_data", rd_b.data, 0);
        drive(0, 1, 0, 0, 0, 0, 1); empty_b = 3'b001; step();
        drive(0, 0, 0, 0, 1, 0, 1); step();
        check("t6_empty_pop", rd_b.data, 0);
        check("t6_err_pulse", rd_b.idx_err, 0);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            pop_a = NA'($urandom_range(0, 15));
            empty_a = NA'($urandom_range(0, 15) & $urandom_range(0, 15));
            pop_b = NB'($urandom_range(0, 7));
            empty_b = NB'($urandom_range(0, 7) & $urandom_range(0, 7));
            idle = ($urandom_range(0, 3) != 0);
            rd_a.req = 1'($urandom_range(0, 1));
            rd_a.idx = 2'($urandom_range(0, 3));
            rd_b.req = 1'($urandom_range(0, 1));
            rd_b.idx = 2'($urandom_range(0, 3));
            if (k == 700) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/word_counter_bank.md
Name: word_counter_bank

Overview:
- Parametrised per-channel word counter bank for the transaction layer. It generalises the fixed 4-channel, 5-bit counter.
- Counts successful pops on each output FIFO and returns a selected count over a req/idx/valid read port.
- Reads are served only while the transaction FSM reports idle. Saturating counters, sticky overflow flags and an optional clear-on-read mode are added.
- Sits beside the output FIFOs and feeds the probador/monitor.

Parameters:
NUM_CHANNELS, 4, number of output FIFOs monitored (1..16).
COUNT_WIDTH, 5, counter and data output width in bits (2..16).
IDX_WIDTH, $clog2(NUM_CHANNELS) (minimum 1), width of idx.
CLEAR_ON_READ, 0, 1 = the counter read is zeroed in the same cycle the read is served.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
pop  input  NUM_CHANNELS  pop strobe per output FIFO.
empty  input  NUM_CHANNELS  empty flag per output FIFO.
idle  input  1  transaction FSM in IDLE (all FIFOs drained).
req  input  1  read request, level-sensitive.
idx  input  IDX_WIDTH  channel to read.
data  output  COUNT_WIDTH  registered count of the selected channel.
valid  output  1  data qualifier, registered.
idx_err  output  1  one-cycle pulse, served read had idx >= NUM_CHANNELS.
overflow  output  NUM_CHANNELS  sticky per-channel saturation flag.

Behaviour:
- Reset (asynchronous, any time, including mid-read):
  - All counters become 0; data=0, valid=0, idx_err=0, overflow=0; FSM goes to S_IDLE.
  - A pending request is discarded.
- Count event on channel i = pop[i] & ~empty[i]. A pop on an empty FIFO is ignored.
- Counter i increments by 1 per count event.
- Saturation: at all-ones (2^COUNT_WIDTH-1) the counter holds and overflow[i] sets. overflow[i] clears only on reset, or when channel i is read with CLEAR_ON_READ=1.
- Counting continues in every FSM state, independent of reads.
- FSM states:
  - S_IDLE: req=0 -> stay; req=1 & idle=1 -> S_SERVE; req=1 & idle=0 -> S_WAIT.
  - S_WAIT: valid=0. req=0 -> S_IDLE (request withdrawn). req=1 & idle=1 -> S_SERVE.
  - S_SERVE: serves one read per cycle. req=1 & idle=1 -> stay. req=1 & idle=0 -> S_WAIT. req=0 -> S_IDLE.
- Read timing:
  - A read is served in every cycle where req=1 and idle=1; the qualifying cycle t is sampled before the FSM transition.
  - In cycle t+1: data = count[idx sampled at t] (pre-increment value of cycle t), valid=1.
  - Latency is exactly 1 clock. Holding req with idle high streams one read per cycle, and idx may change every cycle.
- When no read is served in cycle t: valid=0 at t+1 and data holds its last value.
- Out-of-range idx (NUM_CHANNELS not a power of 2): data=0, valid=1, idx_err=1 for that cycle. No counter is affected.
- CLEAR_ON_READ=1:
  - The read channel is zeroed at the same edge that registers data.
  - If a count event hits the same channel in the serving cycle, the new value is 1, not 0. No event is lost.
- CLEAR_ON_READ=0: reads are non-destructive.
- Simultaneous events on several channels all count in the same cycle.
- idle falling while in S_SERVE: the read of that cycle is not served; the next valid waits for idle to rise again.

Test Plan:
1. Reset, then push 5 words to channel 0 and pop all 5 with empty low, idle=1. req=1, idx=0 for 1 cycle -> next cycle valid=1, data=5; following cycle valid=0.
2. Defaults, 40 pops on channel 3 -> count saturates at 31, overflow=4'b1000. Read idx=3 -> data=31. Assert reset mid-stream -> data=0, valid=0, overflow=0 immediately, without waiting for a clock edge.
3. idle=0, req=1, idx=1, channel 1 count=6 -> valid stays 0 in S_WAIT. Raise idle -> valid=1, data=6 one cycle later. Drop req while waiting instead -> no valid ever.
4. Counts {2,5,2,12} on channels 0..3 (12 needs COUNT_WIDTH>=4). Hold req=1 with idx stepping 0,1,2,3 each cycle -> valid=1 for 4 consecutive cycles, data 2,5,2,12.
5. CLEAR_ON_READ=1, channel 2 count=4. Read idx=2 while a count event hits channel 2 in the same cycle -> data=4, then a reread gives data=1.
6. NUM_CHANNELS=3, req with idx=3 -> valid=1, data=0, idx_err=1 pulse; no counters change. pop[0]=1 with empty[0]=1 -> count 0 unchanged.
